// File: rtl/multi_port_regfile_if.sv
// Operand/writeback bundle for multi_port_regfile: write, reserve and read ports plus
// registered read results, scoreboard bits and the write-collision flag.
interface multi_port_regfile_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int RD_PORTS   = 4,
  parameter int WR_PORTS   = 2
);
  logic                           clk_en;
  logic [WR_PORTS-1:0]            wr_en;
  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr;
  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data;
  logic                           rsv_en;
  logic [ADDR_WIDTH-1:0]          rsv_addr;
  logic [RD_PORTS-1:0]            rd_en;
  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [RD_PORTS-1:0]            rd_valid;
  logic [RD_PORTS-1:0]            rd_pending;
  logic [REG_COUNT-1:0]           busy;
  logic                           wr_conflict;

  modport master (
    output clk_en, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_pending, busy, wr_conflict
  );

  modport slave (
    input  clk_en, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_en, rd_addr,
    output rd_data, rd_valid, rd_pending, busy, wr_conflict
  );
endinterface

// File: rtl/multi_port_regfile.sv
// Multi-ported register file with pending-write scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Reads are registered (1 cycle); no backpressure, clk_en low freezes all state and outputs.
module multi_port_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int RD_PORTS   = 4,
  parameter int WR_PORTS   = 2,
  parameter int ZERO_REG   = 1
) (
  input logic                 clk,
  input logic                 sync_rst,
  multi_port_regfile_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  busy_d;
  logic [REG_COUNT-1:0]  wr_hit;
  logic [REG_COUNT-1:0]  rsv_hit;
  logic [DATA_WIDTH-1:0] wr_val [REG_COUNT];
  logic                  conflict_d;
  logic                  wr_conflict_q;

  logic [ADDR_WIDTH-1:0] wr_addr_a [WR_PORTS];
  logic [DATA_WIDTH-1:0] wr_data_a [WR_PORTS];
  logic [WR_PORTS-1:0]   wr_ok;
  logic [ADDR_WIDTH-1:0] rd_addr_a [RD_PORTS];

  logic [DATA_WIDTH-1:0] rd_data_d [RD_PORTS];
  logic [DATA_WIDTH-1:0] rd_data_q [RD_PORTS];
  logic [RD_PORTS-1:0]   rd_pend_d;
  logic [RD_PORTS-1:0]   rd_pend_q;
  logic [RD_PORTS-1:0]   rd_valid_q;

  // Index 0 (when hardwired) and out-of-range indices never hold state.
  function automatic logic idx_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < REG_LIMIT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      wr_addr_a[p] = bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data_a[p] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      wr_ok[p]     = bus.wr_en[p] && idx_ok(wr_addr_a[p]);
    end
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_addr_a[r] = bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Ascending port scan: a later port overwrites, so the highest-numbered port wins.
  always_comb begin
    wr_hit     = '0;
    conflict_d = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      wr_val[i] = '0;
    end
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_ok[p]) begin
        if (wr_hit[wr_addr_a[p]]) begin
          conflict_d = 1'b1;
        end
        wr_hit[wr_addr_a[p]] = 1'b1;
        wr_val[wr_addr_a[p]] = wr_data_a[p];
      end
    end
  end

  always_comb begin
    rsv_hit = '0;
    if (bus.rsv_en && idx_ok(bus.rsv_addr)) begin
      rsv_hit[bus.rsv_addr] = 1'b1;
    end
    busy_d = (busy_q & ~wr_hit) | rsv_hit;
  end

  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_data_d[r] = '0;
      rd_pend_d[r] = 1'b0;
      if (idx_ok(rd_addr_a[r])) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_d[r] = wr_hit[rd_addr_a[r]] ? wr_val[rd_addr_a[r]] : mem[rd_addr_a[r]];
        rd_pend_d[r] = busy_d[rd_addr_a[r]];
`else
        rd_data_d[r] = mem[rd_addr_a[r]];
        rd_pend_d[r] = busy_q[rd_addr_a[r]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
      for (int r = 0; r < RD_PORTS; r++) begin
        rd_data_q[r] <= '0;
      end
      busy_q        <= '0;
      rd_pend_q     <= '0;
      rd_valid_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else if (bus.clk_en) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_hit[i]) begin
          mem[i] <= wr_val[i];
        end
      end
      busy_q        <= busy_d;
      wr_conflict_q <= conflict_d;
      rd_valid_q    <= bus.rd_en;
      for (int r = 0; r < RD_PORTS; r++) begin
        if (bus.rd_en[r]) begin
          rd_data_q[r] <= rd_data_d[r];
          rd_pend_q[r] <= rd_pend_d[r];
        end
      end
    end
  end

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd_out
    assign bus.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[r];
  end
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_pending  = rd_pend_q;
  assign bus.busy        = busy_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_multi_port_regfile.sv
// Scoreboard bench for multi_port_regfile: directed scenarios then randomized traffic,
// checked against an array-based reference model (follows REGFILE_BYPASS_EN if defined).
module tb_multi_port_regfile;
  localparam int DW = 64;
  localparam int RC = 16;
  localparam int AW = 4;
  localparam int RD = 4;
  localparam int WR = 2;
  localparam int ZR = 1;

  typedef struct packed {
    logic          rst;
    logic [RC-1:0] busy;
    logic          conf;
    logic [RD-1:0] valid;
    logic [RD-1:0] rd_new;
  } exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          pend;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q [$];
  rd_t  rd_q  [$];

  logic [DW-1:0] mem_m [RC];
  logic [RC-1:0] busy_m;
  logic          prev_conf;
  logic [RD-1:0] prev_valid;

  multi_port_regfile_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW),
                          .RD_PORTS(RD), .WR_PORTS(WR)) bus ();

  multi_port_regfile #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW),
                       .RD_PORTS(RD), .WR_PORTS(WR), .ZERO_REG(ZR)) dut (
    .clk      (clk),
    .sync_rst (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.clk_en   = 1'b1;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    rst          = 1'b0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    bus.wr_en[p]            = 1'b1;
    bus.wr_addr[p*AW +: AW] = AW'(a);
    bus.wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int r, input int a);
    bus.rd_en[r]            = 1'b1;
    bus.rd_addr[r*AW +: AW] = AW'(a);
  endtask

  // Reference model: array semantics evaluated at each clock edge, expectations queued.
  task automatic step();
    exp_t          e;
    rd_t           d;
    logic [DW-1:0] nmem [RC];
    logic [RC-1:0] nbusy;
    logic [RC-1:0] written;
    int            a;
    e = '0;
    if (rst) begin
      for (int i = 0; i < RC; i++) mem_m[i] = '0;
      busy_m     = '0;
      prev_conf  = 1'b0;
      prev_valid = '0;
      e.rst      = 1'b1;
    end else if (!bus.clk_en) begin
      e.busy  = busy_m;
      e.conf  = prev_conf;
      e.valid = prev_valid;
    end else begin
      nmem    = mem_m;
      nbusy   = busy_m;
      written = '0;
      for (int p = 0; p < WR; p++) begin
        a = int'(bus.wr_addr[p*AW +: AW]);
        if (bus.wr_en[p] && !(ZR != 0 && a == 0)) begin
          if (written[a]) e.conf = 1'b1;
          written[a] = 1'b1;
          nmem[a]    = bus.wr_data[p*DW +: DW];
          nbusy[a]   = 1'b0;
        end
      end
      a = int'(bus.rsv_addr);
      if (bus.rsv_en && !(ZR != 0 && a == 0)) nbusy[a] = 1'b1;
      for (int r = 0; r < RD; r++) begin
        if (bus.rd_en[r]) begin
          a = int'(bus.rd_addr[r*AW +: AW]);
          d = '0;
          if (!(ZR != 0 && a == 0)) begin
`ifdef REGFILE_BYPASS_EN
            d.data = nmem[a];
            d.pend = nbusy[a];
`else
            d.data = mem_m[a];
            d.pend = busy_m[a];
`endif
          end
          rd_q.push_back(d);
          e.rd_new[r] = 1'b1;
        end
      end
      mem_m      = nmem;
      busy_m     = nbusy;
      e.busy     = nbusy;
      e.valid    = bus.rd_en;
      prev_conf  = e.conf;
      prev_valid = bus.rd_en;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t          e;
    rd_t           d;
    logic [DW-1:0] cur_data [RD];
    logic          cur_pend [RD];
    for (int r = 0; r < RD; r++) begin
      cur_data[r] = '0;
      cur_pend[r] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.rst) begin
          for (int r = 0; r < RD; r++) begin
            cur_data[r] = '0;
            cur_pend[r] = 1'b0;
          end
        end
        for (int r = 0; r < RD; r++) begin
          if (e.rd_new[r]) begin
            if (rd_q.size() == 0) begin
              errors++;
              $display("FAIL rd_q: read expectation missing for port %0d", r);
            end else begin
              d = rd_q.pop_front();
              cur_data[r] = d.data;
              cur_pend[r] = d.pend;
            end
          end
        end
        chk("busy", DW'(bus.busy), DW'(e.busy));
        chk("wr_conflict", DW'(bus.wr_conflict), DW'(e.conf));
        chk("rd_valid", DW'(bus.rd_valid), DW'(e.valid));
        for (int r = 0; r < RD; r++) begin
          chk($sformatf("rd_data[%0d]", r), bus.rd_data[r*DW +: DW], cur_data[r]);
          chk($sformatf("rd_pending[%0d]", r), DW'(bus.rd_pending[r]), DW'(cur_pend[r]));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    idle();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();

    // Reset state then read index 3 on every port.
    idle();
    for (int r = 0; r < RD; r++) set_rd(r, 3);
    step();
    idle(); step();

    // Same-index write collision, port 1 wins.
    idle(); set_wr(0, 5, 64'hA5); set_wr(1, 5, 64'h5A); step();
    idle(); step();
    idle(); set_rd(0, 5); step();

    // Reserve then read, then write with simultaneous read.
    idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7; step();
    idle(); set_rd(1, 7); step();
    idle(); set_wr(0, 7, 64'h77); set_rd(2, 7); step();
    idle(); set_rd(3, 7); step();

    // Reserve and write the same index in one cycle.
    idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 4'd2; set_wr(1, 2, 64'h22); step();
    idle(); set_rd(0, 2); step();

    // Hardwired zero register.
    idle(); set_wr(0, 0, 64'hFFFF); bus.rsv_en = 1'b1; bus.rsv_addr = '0; step();
    idle(); set_rd(1, 0); step();

    // Enable low freezes everything; reset still wins.
    idle(); set_rd(0, 5); step();
    idle(); bus.clk_en = 1'b0; set_wr(0, 9, 64'h99); set_wr(1, 9, 64'h98);
    bus.rsv_en = 1'b1; bus.rsv_addr = 4'd10; set_rd(0, 2); set_rd(1, 7); step();
    step();
    idle(); set_rd(2, 9); step();
    idle(); bus.clk_en = 1'b0; rst = 1'b1; set_wr(0, 4, 64'h44); step();
    idle(); set_rd(0, 5); set_rd(1, 2); step();

    // Randomized traffic with a narrow address range to provoke collisions and forwarding.
    for (int i = 0; i < 800; i++) begin
      idle();
      bus.clk_en = ($urandom_range(0, 9) != 0);
      rst        = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < WR; p++) begin
        if ($urandom_range(0, 1) == 1) set_wr(p, $urandom_range(0, 7), {$urandom(), $urandom()});
      end
      bus.rsv_en   = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = AW'($urandom_range(0, 7));
      for (int r = 0; r < RD; r++) begin
        if ($urandom_range(0, 1) == 1) set_rd(r, $urandom_range(0, 7));
      end
      step();
    end

    idle();
    step();
    @(posedge clk);
    #2;
    chk("exp_q drained", DW'(exp_q.size()), '0);
    chk("rd_q drained", DW'(rd_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
